array_stream_ctrl: RTL
======================

// Module: array_stream_ctrl
// PURPOSE
//  Initiator for the synchronous-write / combinational-read array storage block: owns its
//  index/load/data_in pins. Accepts a command (base index, count, direction), then drains
//  that many entries to an output valid/ready stream or fills them from an input stream.
//  Sits between the array and any bulk mover (cache line writeback/refill, init loader).
// PARAMETERS
//  width   128  bits per array entry / stream beat
//  height  8    array depth; IW = $clog2(height), CW = $clog2(height+1)
// PORTS
//  clk          in   1      clock; all state updates on posedge
//  rst          in   1      synchronous, active-high reset
//  cmd_valid    in   1      command offered
//  cmd_ready    out  1      1 only in IDLE; command accepted on cmd_valid & cmd_ready
//  cmd_write    in   1      1 = FILL (stream -> array), 0 = DRAIN (array -> stream)
//  cmd_base     in   IW     first entry index
//  cmd_count    in   CW     entries to move, 0..height; values > height clamp to height
//  arr_load     out  1      to array load
//  arr_index    out  IW     to array index
//  arr_wdata    out  width  to array data_in
//  arr_rdata    in   width  from array data_out (combinational read of arr_index)
//  out_valid    out  1      drain beat valid
//  out_ready    in   1      downstream accepts beat
//  out_data     out  width  drain beat data
//  in_valid     in   1      fill beat valid
//  in_ready     out  1      this block accepts fill beat
//  in_data      in   width  fill beat data
//  busy         out  1      1 in DRAIN/FILL/DONE
//  done         out  1      one-cycle pulse, command finished
// BEHAVIOUR
//  - States IDLE, DRAIN, FILL, DONE. Reset -> IDLE; ptr=0, remaining=0.
//  - Reset values: cmd_ready=1, arr_load=0, arr_index=0, arr_wdata=0, out_valid=0,
//    out_data=0, in_ready=0, busy=0, done=0.
//  - IDLE: on accept latch ptr=cmd_base, remaining=min(cmd_count,height);
//    remaining==0 -> DONE; else cmd_write ? FILL : DRAIN. Next cycle is first beat cycle.
//  - DRAIN: arr_index=ptr, out_valid=1, out_data=arr_rdata (zero-latency pass-through);
//    beat on out_valid&out_ready: ptr advances, remaining--; last beat -> DONE.
//    out_valid held with stable data while out_ready=0 (no other array writer in DRAIN).
//  - FILL: arr_index=ptr, in_ready=1, arr_wdata=in_data, arr_load=in_valid (same cycle);
//    each beat writes entry ptr, ptr advances, remaining--; last beat -> DONE.
//  - arr_load=0 in every state except FILL; out_valid=0 outside DRAIN; in_ready=0 outside FILL.
//  - arr_index = ptr in all states (IDLE: last ptr, 0 after reset).
//  - Ptr wrap: ptr==height-1 advances to 0 (explicit compare; holds for non-power-of-2).
//  - DONE: done=1 for exactly one cycle, cmd_ready=0, -> IDLE. Min command = 3 cycles
//    (accept, beat, DONE); count 0 = accept, DONE.
//  - Throughput 1 beat/cycle with continuous handshake; back-to-back commands have a
//    2-cycle gap (DONE, IDLE accept).
//  - rst mid-command: abort, state IDLE next cycle, no done pulse, no further arr_load;
//    entries already written stay written.
//  - cmd_valid outside IDLE ignored (not queued). Unused stream side's inputs ignored.
// TESTING
//  1 Fill base=2 count=4, in_valid=1 data 0xA0..0xA3 -> entries 2..5 = A0..A3, 4 loads, done pulse
//    one cycle after last beat.
//  2 Drain base=2 count=4, out_ready=1 -> out_data A0,A1,A2,A3 on consecutive cycles, done.
//  3 Wrap: fill base=6 count=4 -> entries 6,7,0,1 written; entry 2 untouched.
//  4 Backpressure: drain count=3, out_ready toggling 1,0,0,1,1 -> 3 beats, data stable while
//    stalled, no duplicates; fill with in_valid gaps -> arr_load only on valid cycles.
//  5 count=0 -> no array/stream activity, done 1 cycle after accept; count=15 (height=8) ->
//    exactly 8 beats.
//  6 rst asserted after 2nd of 4 fill beats -> IDLE, busy=0, no done, only 2 entries written;
//    next command accepted normally.

Source files
------------

// File: rtl/array_stream_ctrl.sv
// Bulk mover between a sync-write / comb-read array and a pair of valid/ready streams.
// A command drains entries base..base+count-1 to out_* or fills them from in_*.
module array_stream_ctrl #(
    parameter int width  = 128,
    parameter int height = 8,
    localparam int IW = $clog2(height),
    localparam int CW = $clog2(height + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [IW-1:0]    cmd_base,
    input  logic [CW-1:0]    cmd_count,
    output logic             arr_load,
    output logic [IW-1:0]    arr_index,
    output logic [width-1:0] arr_wdata,
    input  logic [width-1:0] arr_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FILL, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   w_ptr_next;
    logic [CW-1:0]   r_remaining;
    logic [CW-1:0]   w_remaining_next;
    logic [IW-1:0]   w_ptr_inc;
    logic [CW-1:0]   w_count_clamped;
    logic            w_beat;

    // Explicit wrap compare so non-power-of-2 depths stay inside the array.
    assign w_ptr_inc       = (r_ptr == IW'(height - 1)) ? '0 : r_ptr + IW'(1);
    assign w_count_clamped = (cmd_count > CW'(height)) ? CW'(height) : cmd_count;
    assign w_beat          = ((r_state == S_DRAIN) && out_ready) ||
                             ((r_state == S_FILL)  && in_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_remaining <= w_remaining_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_ptr_next       = r_ptr;
        w_remaining_next = r_remaining;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_ptr_next       = cmd_base;
                    w_remaining_next = w_count_clamped;
                    if (w_count_clamped == '0) begin
                        w_state_next = S_DONE;
                    end else if (cmd_write) begin
                        w_state_next = S_FILL;
                    end else begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN, S_FILL: begin
                if (w_beat) begin
                    w_ptr_next       = w_ptr_inc;
                    w_remaining_next = r_remaining - CW'(1);
                    if (r_remaining == CW'(1)) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Stream/array strobes are masked during rst so an aborted fill cannot write on the reset edge.
    always_comb begin
        cmd_ready = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE) && !rst;
        arr_index = r_ptr;
        arr_load  = 1'b0;
        arr_wdata = '0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        if (!rst) begin
            if (r_state == S_FILL) begin
                in_ready  = 1'b1;
                arr_load  = in_valid;
                arr_wdata = in_data;
            end
            if (r_state == S_DRAIN) begin
                out_valid = 1'b1;
                out_data  = arr_rdata;
            end
        end
    end

endmodule
